instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side types: next-PC select encoding, fetch FSM states
// and the instruction buffer entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_DROP = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {instr, pc} pairs in fetch order.
// Power-of-two depth, so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding memory requester feeding a small
// buffer, with redirect handling for taken branches, JAL and JALR.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nReset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_nxt;
  logic [31:0]  target;
  logic         redir_sel;
  logic         redirect;
  logic         grant;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [CW-1:0] count;
  logic [CW:0]  occ;
  logic         in_wait;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  always_comb begin
    redir_sel = 1'b0;
    target    = fetch_pc;
    unique case (1'b1)
      (PCSrc == PC_BRANCH): begin
        redir_sel = 1'b1;
        target    = PC + ImmExt;
      end
      (PCSrc == PC_JALR): begin
        redir_sel = 1'b1;
        target    = ALUResult;
      end
      default: ;
    endcase
    target[1:0] = 2'b00;
  end

  assign redirect = InstrValid & InstrReady & redir_sel;
  assign in_wait  = (state == F_WAIT);

  // A response landing this cycle still occupies a slot; pops are not credited.
  assign occ = {1'b0, count} + (CW+1)'(in_wait);

  assign IMemReq = nReset & ~redirect
                 & ((state == F_IDLE) | (in_wait & IMemRValid))
                 & (occ < (CW+1)'(DEPTH));

  assign IMemAddr = fetch_pc;
  assign grant    = IMemReq & IMemGnt;
  assign push     = in_wait & IMemRValid & ~redirect & ~full;
  assign pop      = InstrValid & InstrReady & ~redirect;

  // The outstanding request always targets the word before fetch_pc.
  assign wr_entry = '{instr: IMemRData, pc: fetch_pc - 32'd4};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (nReset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign InstrValid = ~empty;
  assign Instr      = empty ? '0 : head.instr;
  assign PC         = empty ? '0 : head.pc;
  assign PCPlus4    = PC + 32'd4;

  always_comb begin
    state_nxt = state;
    unique case (state)
      F_IDLE: begin
        if (grant) state_nxt = F_WAIT;
      end
      F_WAIT: begin
        if (redirect) begin
          state_nxt = IMemRValid ? F_IDLE : F_DROP;
        end else if (IMemRValid && !grant) begin
          state_nxt = F_IDLE;
        end
      end
      F_DROP: begin
        if (IMemRValid) state_nxt = F_IDLE;
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect) begin
      fetch_pc_nxt = target;
    end else if (grant) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= F_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Random and directed bench for instr_fetch against a queue-based
// reference model and an in-order single-outstanding memory.
module tb_instr_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        nReset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        InstrReady;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;

  instr_fetch #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemGnt    (IMemGnt),
    .IMemRValid (IMemRValid),
    .IMemRData  (IMemRData),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .PCSrc      (PCSrc),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory: addresses granted and not yet answered
  logic [31:0] mq [$];
  logic        s_req;
  logic [31:0] s_addr;

  // reference model
  logic [63:0] m_q [$];
  logic [31:0] m_fpc;
  logic [31:0] m_oaddr;
  bit          m_out;
  bit          m_disc;
  logic        m_req;
  logic        m_valid;
  logic        m_redir;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_target;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc  = RPC;
    m_out  = 0;
    m_disc = 0;
  endtask

  task automatic model_comb();
    m_valid = (m_q.size() > 0);
    m_instr = m_valid ? m_q[0][63:32] : 32'h0;
    m_pc    = m_valid ? m_q[0][31:0] : 32'h0;
    m_redir = m_valid && InstrReady
            && (PCSrc == 2'b01 || PCSrc == 2'b10);
    if (PCSrc == 2'b01) m_target = m_pc + ImmExt;
    else m_target = ALUResult;
    m_target[1:0] = 2'b00;
    m_req = nReset && !m_redir && !m_disc
          && (!m_out || IMemRValid)
          && (m_q.size() + int'(m_out) < DEPTH);
  endtask

  task automatic drive(input logic rst, input logic rdy,
                       input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] alu, input logic gnt,
                       input logic rv_en);
    @(negedge clk);
    nReset     = rst;
    InstrReady = rdy;
    PCSrc      = src;
    ImmExt     = imm;
    ALUResult  = alu;
    IMemGnt    = gnt;
    IMemRValid = rv_en && (mq.size() > 0);
    IMemRData  = IMemRValid ? memf(mq[0]) : 32'hDEAD_BEEF;
    if (!rst) model_reset();
    #1;
    model_comb();
    chk("IMemReq", IMemReq, m_req);
    chk("IMemAddr", IMemAddr, m_fpc);
    chk("InstrValid", InstrValid, m_valid);
    chk("Instr", Instr, m_instr);
    chk("PC", PC, m_pc);
    chk("PCPlus4", PCPlus4, m_pc + 32'd4);
    s_req  = IMemReq;
    s_addr = IMemAddr;
  endtask

  task automatic adv();
    bit resp;
    bit gntd;
    @(posedge clk);
    if (IMemRValid) void'(mq.pop_front());
    if (s_req && IMemGnt) mq.push_back(s_addr);
    if (nReset) begin
      resp = IMemRValid && m_out;
      gntd = m_req && IMemGnt;
      if (m_redir) m_q.delete();
      else if (m_valid && InstrReady) void'(m_q.pop_front());
      if (resp) begin
        if (!m_disc && !m_redir) m_q.push_back({IMemRData, m_oaddr});
        m_out  = 0;
        m_disc = 0;
      end
      if (gntd) begin
        m_out   = 1;
        m_oaddr = m_fpc;
        m_fpc   = m_fpc + 32'd4;
      end
      if (m_redir) begin
        m_fpc = m_target;
        if (m_out) m_disc = 1;
      end
    end
  endtask

  initial begin
    int r;
    logic [1:0] src;
    nReset = 0; InstrReady = 0; PCSrc = 0; ImmExt = 0;
    ALUResult = 0; IMemGnt = 0; IMemRValid = 0; IMemRData = 0;
    model_reset();

    // held in reset
    drive(0, 1, 0, 0, 0, 1, 1);
    chk("rst_req", IMemReq, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", Instr, 0);
    chk("rst_pc", PC, 0);
    chk("rst_pc4", PCPlus4, 32'h4);
    adv();
    drive(0, 1, 0, 0, 0, 1, 1); adv();

    // zero-wait streaming
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("c0_req", IMemReq, 1);
    chk("c0_addr", IMemAddr, 32'h0);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("c1_addr", IMemAddr, 32'h4);
    chk("c1_valid", InstrValid, 0);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("c2_addr", IMemAddr, 32'h8);
    chk("c2_valid", InstrValid, 1);
    chk("c2_pc", PC, 32'h0);
    chk("c2_instr", Instr, memf(32'h0));
    adv();
    for (int i = 3; i < 6; i++) begin
      drive(1, 1, 0, 0, 0, 1, 1); adv();
    end

    // BEQ taken at 0x10 back to 0x0 with the 0x14 response landing
    drive(1, 1, 2'b01, 32'hFFFF_FFF0, 0, 1, 1);
    chk("beq_pc", PC, 32'h10);
    chk("beq_req", IMemReq, 0);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("beq_addr", IMemAddr, 32'h0);
    chk("beq_req2", IMemReq, 1);
    chk("beq_flush", InstrValid, 0);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1); adv();

    // consumer stall for five cycles
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 1, 1);
      if (i == 4) begin
        chk("stall_req", IMemReq, 0);
        chk("stall_pc", PC, 32'h0);
        chk("stall_valid", InstrValid, 1);
      end
      adv();
    end
    drive(1, 1, 0, 0, 0, 1, 0);
    chk("rel_pc0", PC, 32'h0);
    adv();

    // JALR while 0x10 is outstanding
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("rel_pc4", PC, 32'h4);
    chk("jalr_pre_addr", IMemAddr, 32'h10);
    adv();
    drive(1, 1, 2'b10, 0, 32'h103, 1, 0);
    chk("jalr_req", IMemReq, 0);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("drop_req", IMemReq, 0);
    chk("drop_valid", InstrValid, 0);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("jalr_addr", IMemAddr, 32'h100);
    chk("jalr_req2", IMemReq, 1);
    adv();
    drive(1, 1, 0, 0, 0, 1, 1); adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("jalr_pc", PC, 32'h100);
    adv();

    // reset while a request is outstanding
    drive(0, 1, 0, 0, 0, 1, 0);
    chk("mrst_req", IMemReq, 0);
    chk("mrst_valid", InstrValid, 0);
    chk("mrst_pc", PC, 0);
    adv();
    drive(0, 1, 0, 0, 0, 1, 1); adv();
    drive(1, 1, 0, 0, 0, 1, 1);
    chk("mrst_addr", IMemAddr, RPC);
    chk("mrst_req2", IMemReq, 1);
    adv();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        drive(0, 1, 0, 0, 0, 0, 1); adv();
        drive(0, 1, 0, 0, 0, 0, 1); adv();
      end
      r = $urandom_range(0, 15);
      src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 :
            (r == 2) ? 2'b11 : 2'b00;
      drive(1, $urandom_range(0, 3) != 0, src,
            {22'($urandom_range(0, 63)), 10'h0} - 32'h8000,
            $urandom & 32'h0000_0FFF,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
